// File: rtl/fsm_go_sequencer_if.sv
// Handshake bundle between upstream request logic, the 4-state run FSM and fsm_go_sequencer.
// The master side drives req/err_clr and returns the FSM state. The slave side is the sequencer.
interface fsm_go_sequencer_if #(
   parameter int PEND_W = 4,
   parameter int CNT_W  = 16
);
   // req is accepted on any rising clock edge where req && req_ready.
   // There is no hold requirement: a req seen while full is simply dropped.
   logic              req;
   logic              req_ready;
   logic              go;
   logic [1:0]        state;
   logic              err_clr;
   logic [PEND_W-1:0] pending;
   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  done_count;
   logic              err;

   modport master (
      output req, state, err_clr,
      input  req_ready, go, pending, busy, done, done_count, err
   );

   modport slave (
      input  req, state, err_clr,
      output req_ready, go, pending, busy, done, done_count, err
   );
endinterface

// File: rtl/fsm_go_sequencer.sv
// Queues run requests, pulses go once per run while the run FSM is idle, then checks that the
// FSM walks 1->2->3->0 in lockstep. Reports done pulses, a wrapping count and a sticky error.
module fsm_go_sequencer #(
   parameter int PEND_W  = 4,
   parameter int CNT_W   = 16,
   parameter int MIN_GAP = 0
) (
   input  logic                clock,
   input  logic                reset_n,
   fsm_go_sequencer_if.slave   bus,
   output logic [2:0]          dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_EXP1  = 3'd2,
      S_EXP2  = 3'd3,
      S_EXP3  = 3'd4,
      S_EXP0  = 3'd5,
      S_GAP   = 3'd6,
      S_ERR   = 3'd7
   } seq_state_e;

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [3:0]        GAP_LOAD = (MIN_GAP > 0) ? 4'(MIN_GAP - 1) : 4'd0;

   seq_state_e        state_q;
   logic              go_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic [PEND_W-1:0] pending_q;
   logic [PEND_W-1:0] pending_d;
   logic [CNT_W-1:0]  done_count_q;
   logic [3:0]        gap_q;

   logic req_ready;
   logic req_acc;
   logic launch;

   assign req_ready = (pending_q != PEND_MAX);
   assign req_acc   = bus.req && req_ready;
   // A nonzero FSM state while idle just delays the launch.
   assign launch    = (state_q == S_IDLE) && (pending_q != '0) && (bus.state == 2'd0);

   always_comb begin
      pending_d = pending_q;
      if (req_acc && !launch) begin
         pending_d = pending_q + 1'b1;
      end else if (!req_acc && launch) begin
         pending_d = pending_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         go_q         <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         pending_q    <= '0;
         done_count_q <= '0;
         gap_q        <= 4'd0;
      end else begin
         pending_q <= pending_d;
         go_q      <= 1'b0;
         done_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (launch) begin
                  state_q <= S_ISSUE;
                  go_q    <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_ISSUE: begin
               state_q <= S_EXP1;
            end
            S_EXP1: begin
               if (bus.state == 2'd1) begin
                  state_q <= S_EXP2;
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_EXP2: begin
               if (bus.state == 2'd2) begin
                  state_q <= S_EXP3;
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_EXP3: begin
               if (bus.state == 2'd3) begin
                  state_q <= S_EXP0;
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            S_EXP0: begin
               busy_q <= 1'b0;
               if (bus.state == 2'd0) begin
                  done_q       <= 1'b1;
                  done_count_q <= done_count_q + 1'b1;
                  if (MIN_GAP > 0) begin
                     state_q <= S_GAP;
                     gap_q   <= GAP_LOAD;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end
            end
            S_GAP: begin
               if (gap_q == 4'd0) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            S_ERR: begin
               if (bus.err_clr) begin
                  err_q   <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.go         = go_q;
   assign bus.pending    = pending_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.done_count = done_count_q;
   assign bus.err        = err_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_fsm_go_sequencer.sv
// Directed bench: two sequencers (default, and PEND_W=2/CNT_W=2/MIN_GAP=2), each driving a model
// of the 4-state run FSM. Instance A's state input can be overridden to inject a mismatch.
module tb_fsm_go_sequencer;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   fsm_go_sequencer_if #(.PEND_W(4), .CNT_W(16)) ifa ();
   fsm_go_sequencer_if #(.PEND_W(2), .CNT_W(2))  ifb ();

   logic [2:0] dbg_a;
   logic [2:0] dbg_b;
   logic [1:0] fsm_a;
   logic [1:0] fsm_b;
   logic       ovr_en;
   logic [1:0] ovr_val;

   int checks = 0;
   int errors = 0;

   fsm_go_sequencer #(.PEND_W(4), .CNT_W(16), .MIN_GAP(0)) dut_a (
      .clock(clock), .reset_n(reset_n), .bus(ifa), .dbg_state_o(dbg_a));
   fsm_go_sequencer #(.PEND_W(2), .CNT_W(2), .MIN_GAP(2)) dut_b (
      .clock(clock), .reset_n(reset_n), .bus(ifb), .dbg_state_o(dbg_b));

   // Run FSM: 0 --go--> 1 -> 2 -> 3 -> 0
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) fsm_a <= 2'd0;
      else if (fsm_a != 2'd0 || ifa.go) fsm_a <= fsm_a + 2'd1;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) fsm_b <= 2'd0;
      else if (fsm_b != 2'd0 || ifb.go) fsm_b <= fsm_b + 2'd1;
   end

   assign ifa.state = ovr_en ? ovr_val : fsm_a;
   assign ifb.state = fsm_b;

   task automatic test_reset();
      reset_n = 1'b1;
      #2 reset_n = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (ifa.go !== 1'b0) begin errors++; $display("FAIL rst_go got %0b exp 0", ifa.go); end
      checks++; if (ifa.pending !== 4'd0) begin errors++; $display("FAIL rst_pending got %0d exp 0", ifa.pending); end
      checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", ifa.err); end
      checks++; if (ifa.done_count !== 16'd0) begin errors++; $display("FAIL rst_done_count got %0d exp 0", ifa.done_count); end
      checks++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0) begin errors++; $display("FAIL rst_busy_done got %0b%0b exp 00", ifa.busy, ifa.done); end
      checks++; if (ifb.pending !== 2'd0 || ifb.done_count !== 2'd0) begin errors++; $display("FAIL rst_b_counters got %0d/%0d exp 0/0", ifb.pending, ifb.done_count); end
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      checks++; if (ifa.req_ready !== 1'b1 || ifb.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0b%0b exp 11", ifa.req_ready, ifb.req_ready); end
      checks++; if (fsm_a !== 2'd0 || ifa.go !== 1'b0) begin errors++; $display("FAIL rst_idle_state got fsm=%0d go=%0b exp 0/0", fsm_a, ifa.go); end
      checks++; if (dbg_a !== 3'd0 || dbg_b !== 3'd0) begin errors++; $display("FAIL rst_dbg got %0d/%0d exp 0/0", dbg_a, dbg_b); end
   endtask

   // One run on A; expects go at i=2, FSM 1,2,3 at i=3..5, done at i=7.
   task automatic test_single_run();
      logic       e_go, e_done, e_busy;
      logic [1:0] e_st;
      logic [2:0] e_dbg;
      int         e_p, e_cnt;
      @(negedge clock);
      ifa.req = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         e_go   = (i == 2);
         e_done = (i == 7);
         e_busy = (i >= 2 && i <= 6);
         e_st   = (i >= 3 && i <= 5) ? 2'(i - 2) : 2'd0;
         e_dbg  = (i >= 2 && i <= 6) ? 3'(i - 1) : 3'd0;
         e_p    = (i == 1) ? 1 : 0;
         e_cnt  = (i >= 7) ? 1 : 0;
         checks++; if (ifa.go !== e_go) begin errors++; $display("FAIL single_go i=%0d got %0b exp %0b", i, ifa.go, e_go); end
         checks++; if (ifa.done !== e_done) begin errors++; $display("FAIL single_done i=%0d got %0b exp %0b", i, ifa.done, e_done); end
         checks++; if (ifa.busy !== e_busy) begin errors++; $display("FAIL single_busy i=%0d got %0b exp %0b", i, ifa.busy, e_busy); end
         checks++; if (fsm_a !== e_st) begin errors++; $display("FAIL single_fsm i=%0d got %0d exp %0d", i, fsm_a, e_st); end
         checks++; if (dbg_a !== e_dbg) begin errors++; $display("FAIL single_dbg i=%0d got %0d exp %0d", i, dbg_a, e_dbg); end
         checks++; if (ifa.pending !== 4'(e_p)) begin errors++; $display("FAIL single_pending i=%0d got %0d exp %0d", i, ifa.pending, e_p); end
         checks++; if (ifa.done_count !== 16'(e_cnt)) begin errors++; $display("FAIL single_count i=%0d got %0d exp %0d", i, ifa.done_count, e_cnt); end
         ifa.req     = 1'b0;
         ifa.err_clr = (i == 4);
      end
      ifa.err_clr = 1'b0;
      checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL single_err got %0b exp 0", ifa.err); end
   endtask

   // Three reqs queued while A sees a nonzero state in IDLE, then drained at a 6-cycle period.
   task automatic test_back_to_back();
      logic e_go, e_done;
      int   e_p, e_cnt;
      @(negedge clock);
      ovr_en  = 1'b1;
      ovr_val = 2'd2;
      ifa.req = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         @(negedge clock);
         e_go   = (i == 5 || i == 11 || i == 17);
         e_done = (i == 10 || i == 16 || i == 22);
         e_p    = (i <= 3) ? i : (i == 4) ? 3 : (i <= 10) ? 2 : (i <= 16) ? 1 : 0;
         e_cnt  = 1 + int'(i >= 10) + int'(i >= 16) + int'(i >= 22);
         checks++; if (ifa.go !== e_go) begin errors++; $display("FAIL b2b_go i=%0d got %0b exp %0b", i, ifa.go, e_go); end
         checks++; if (ifa.done !== e_done) begin errors++; $display("FAIL b2b_done i=%0d got %0b exp %0b", i, ifa.done, e_done); end
         checks++; if (ifa.pending !== 4'(e_p)) begin errors++; $display("FAIL b2b_pending i=%0d got %0d exp %0d", i, ifa.pending, e_p); end
         checks++; if (ifa.done_count !== 16'(e_cnt)) begin errors++; $display("FAIL b2b_count i=%0d got %0d exp %0d", i, ifa.done_count, e_cnt); end
         if (i <= 4) begin
            checks++; if (dbg_a !== 3'd0 || ifa.err !== 1'b0) begin errors++; $display("FAIL b2b_idle_hold i=%0d got dbg=%0d err=%0b exp 0/0", i, dbg_a, ifa.err); end
         end
         ifa.req = (i < 3);
         ovr_en  = (i < 4);
      end
      checks++; if (ifa.err !== 1'b0) begin errors++; $display("FAIL b2b_err got %0b exp 0", ifa.err); end
   endtask

   // B (PEND_W=2, MIN_GAP=2, CNT_W=2): saturation, 8-cycle period, done_count wrap.
   task automatic test_saturation();
      logic e_go, e_done;
      int   e_p, e_cnt;
      @(negedge clock);
      ifb.req = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clock);
         e_go   = (i == 2 || i == 10 || i == 18 || i == 26);
         e_done = (i == 7 || i == 15 || i == 23 || i == 31);
         e_p    = (i == 1) ? 1 : (i == 2) ? 0 : (i <= 4) ? i - 2 : (i <= 9) ? 3 :
                  (i <= 17) ? 2 : (i <= 25) ? 1 : 0;
         e_cnt  = (int'(i >= 7) + int'(i >= 15) + int'(i >= 23) + int'(i >= 31)) % 4;
         checks++; if (ifb.go !== e_go) begin errors++; $display("FAIL sat_go i=%0d got %0b exp %0b", i, ifb.go, e_go); end
         checks++; if (ifb.done !== e_done) begin errors++; $display("FAIL sat_done i=%0d got %0b exp %0b", i, ifb.done, e_done); end
         checks++; if (ifb.pending !== 2'(e_p)) begin errors++; $display("FAIL sat_pending i=%0d got %0d exp %0d", i, ifb.pending, e_p); end
         checks++; if (ifb.req_ready !== (e_p != 3)) begin errors++; $display("FAIL sat_req_ready i=%0d got %0b exp %0b", i, ifb.req_ready, (e_p != 3)); end
         checks++; if (ifb.done_count !== 2'(e_cnt)) begin errors++; $display("FAIL sat_count i=%0d got %0d exp %0d", i, ifb.done_count, e_cnt); end
         if (i == 8) begin
            checks++; if (dbg_b !== 3'd6) begin errors++; $display("FAIL sat_gap_state got %0d exp 6", dbg_b); end
         end
         if (i == 9) begin
            checks++; if (dbg_b !== 3'd0) begin errors++; $display("FAIL sat_gap_exit got %0d exp 0", dbg_b); end
         end
         ifb.req = (i >= 2 && i <= 6);
      end
      checks++; if (ifb.err !== 1'b0) begin errors++; $display("FAIL sat_err got %0b exp 0", ifb.err); end
   endtask

   // Mismatch in EXP1 on A, two reqs held in ERR, then err_clr resumes and drains them.
   task automatic test_error_recovery();
      logic e_go, e_err;
      int   e_p, e_cnt;
      @(negedge clock);
      ifa.req = 1'b1;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clock);
         e_go  = (i == 2 || i == 13 || i == 19);
         e_err = (i >= 4 && i <= 11);
         e_p   = (i == 1) ? 1 : (i <= 4) ? 0 : (i == 5) ? 1 : (i <= 12) ? 2 : (i <= 18) ? 1 : 0;
         e_cnt = 4 + int'(i >= 18) + int'(i >= 24);
         checks++; if (ifa.go !== e_go) begin errors++; $display("FAIL err_go i=%0d got %0b exp %0b", i, ifa.go, e_go); end
         checks++; if (ifa.err !== e_err) begin errors++; $display("FAIL err_flag i=%0d got %0b exp %0b", i, ifa.err, e_err); end
         checks++; if (ifa.pending !== 4'(e_p)) begin errors++; $display("FAIL err_pending i=%0d got %0d exp %0d", i, ifa.pending, e_p); end
         checks++; if (ifa.done_count !== 16'(e_cnt)) begin errors++; $display("FAIL err_count i=%0d got %0d exp %0d", i, ifa.done_count, e_cnt); end
         if (e_err) begin
            checks++; if (dbg_a !== 3'd7 || ifa.busy !== 1'b0) begin errors++; $display("FAIL err_state i=%0d got dbg=%0d busy=%0b exp 7/0", i, dbg_a, ifa.busy); end
         end
         if (i == 12) begin
            checks++; if (dbg_a !== 3'd0) begin errors++; $display("FAIL err_clr_idle got %0d exp 0", dbg_a); end
         end
         ifa.req     = (i == 4 || i == 5);
         ovr_en      = (i == 2 || i == 3);
         ifa.err_clr = (i == 11);
      end
   endtask

   // Reset asserted while A sits in EXP2 with a queued request and a nonzero done_count.
   task automatic test_reset_mid_run();
      @(negedge clock);
      ifa.req = 1'b1;
      repeat (2) @(negedge clock);
      ifa.req = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (dbg_a !== 3'd3 || ifa.pending !== 4'd1 || ifa.done_count !== 16'd6) begin
         errors++; $display("FAIL mid_pre got dbg=%0d pend=%0d cnt=%0d exp 3/1/6", dbg_a, ifa.pending, ifa.done_count); end
      reset_n = 1'b0;
      #1;
      checks++; if (ifa.go !== 1'b0 || ifa.busy !== 1'b0 || dbg_a !== 3'd0) begin
         errors++; $display("FAIL mid_async_state got go=%0b busy=%0b dbg=%0d exp 0/0/0", ifa.go, ifa.busy, dbg_a); end
      checks++; if (ifa.pending !== 4'd0 || ifa.done_count !== 16'd0 || ifa.err !== 1'b0) begin
         errors++; $display("FAIL mid_async_counters got pend=%0d cnt=%0d err=%0b exp 0/0/0", ifa.pending, ifa.done_count, ifa.err); end
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      checks++; if (fsm_a !== 2'd0 || ifa.pending !== 4'd0) begin errors++; $display("FAIL mid_release got fsm=%0d pend=%0d exp 0/0", fsm_a, ifa.pending); end
   endtask

   initial begin
      ifa.req     = 1'b0;
      ifa.err_clr = 1'b0;
      ifb.req     = 1'b0;
      ifb.err_clr = 1'b0;
      ovr_en      = 1'b0;
      ovr_val     = 2'd0;
      test_reset();
      test_single_run();
      test_back_to_back();
      test_saturation();
      test_error_recovery();
      test_reset_mid_run();
      test_single_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
